// File: rtl/fetch_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue_if
// Groups the instruction-memory handshake and the decode-side signals of the
// prefetching fetch unit.
//   master : the fetch unit (drives mem_start/mem_addr and the id_* outputs)
//   slave  : the surrounding core/memory (drives responses, stall, redirect)
// Signals:
//   mem_start       request valid           mem_ready       request accepted
//   mem_addr        request address         mem_data        returned instruction
//   mem_data_valid  response valid          stall_flg       decode holds head
//   redirect_valid  flush + restart fetch   redirect_pc     new fetch PC
//   id_valid        FIFO non-empty          id_reg_pc       head PC (0 if empty)
//   id_inst         head instruction (NOP when empty)
// ---------------------------------------------------------------------------
interface fetch_prefetch_queue_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            mem_start;
    logic            mem_ready;
    logic [XLEN-1:0] mem_addr;
    logic [ILEN-1:0] mem_data;
    logic            mem_data_valid;
    logic            stall_flg;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic [XLEN-1:0] id_reg_pc;
    logic [ILEN-1:0] id_inst;

    modport master (
        output mem_start, mem_addr, id_valid, id_reg_pc, id_inst,
        input  mem_ready, mem_data, mem_data_valid, stall_flg,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_start, mem_addr, id_valid, id_reg_pc, id_inst,
        output mem_ready, mem_data, mem_data_valid, stall_flg,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue
// Instruction fetch unit with a DEPTH-entry prefetch FIFO of {pc, inst}.
// Issues at most one outstanding instruction-memory request, buffers the
// responses, presents the FIFO head to decode and flushes on redirect.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_prefetch_queue_if.master (memory handshake + decode outputs)
// All outputs are registers or decoded from registers only.
// ---------------------------------------------------------------------------
module fetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [ILEN-1:0] NOP_INST = ILEN'(32'h0000_0013)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fetch_prefetch_queue_if.master  bus
);
    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic [1:0]       state, state_next;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_pc;
    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [ILEN-1:0]  inst_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             accept, push, pop, outstanding, has_space, head_valid;

    assign accept      = (state == ST_REQ) && bus.mem_ready;
    assign outstanding = (state == ST_WAIT);
    assign head_valid  = (count != '0);
    // A FIFO slot is reserved for the outstanding request so a push can
    // never land on a full FIFO.
    assign has_space   = (count + CNT_W'(outstanding)) < DEPTH_C;

    always_comb begin
        push = (state == ST_WAIT) && bus.mem_data_valid && !bus.redirect_valid;
        pop  = head_valid && !bus.stall_flg && !bus.redirect_valid;

        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;

        state_next = state;
        if (bus.redirect_valid) begin
            // Any request already accepted by memory must have its response
            // swallowed before fetching from the new PC.
            if ((state == ST_WAIT && !bus.mem_data_valid) ||
                (state == ST_REQ && bus.mem_ready) ||
                (state == ST_DISCARD && !bus.mem_data_valid))
                state_next = ST_DISCARD;
            else
                state_next = ST_REQ;
        end else begin
            case (state)
                ST_IDLE:    if (has_space) state_next = ST_REQ;
                ST_REQ:     if (bus.mem_ready) state_next = ST_WAIT;
                ST_WAIT:    if (bus.mem_data_valid)
                                state_next = (count_next < DEPTH_C) ? ST_REQ : ST_IDLE;
                ST_DISCARD: if (bus.mem_data_valid) state_next = ST_REQ;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // Control state: FSM, fetch PC, FIFO bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state <= state_next;
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + XLEN'(4);
                count <= count_next;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Datapath storage: only ever observed through count, so no reset
    always_ff @(posedge clk) begin
        if (accept)
            req_pc <= fetch_pc;
        if (push) begin
            pc_mem[wr_ptr]   <= req_pc;
            inst_mem[wr_ptr] <= bus.mem_data;
        end
    end

    assign bus.mem_start = (state == ST_REQ);
    assign bus.mem_addr  = fetch_pc;
    assign bus.id_valid  = head_valid;
    assign bus.id_reg_pc = head_valid ? pc_mem[rd_ptr]   : '0;
    assign bus.id_inst   = head_valid ? inst_mem[rd_ptr] : NOP_INST;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_queue
// Directed bench for fetch_prefetch_queue. A small memory model answers each
// accepted request one cycle later with inst = addr ^ 32'hA5A5_0000 unless
// responses are held back (resp_en = 0).
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_queue;
    localparam int          XLEN  = 32;
    localparam int          ILEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic        pend_valid = 1'b0;
    logic [31:0] pend_addr  = '0;
    logic        resp_en    = 1'b1;
    int          req_cnt;

    fetch_prefetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

    fetch_prefetch_queue #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH),
        .RESET_PC(32'h0), .NOP_INST(NOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs for the new cycle are applied 1 time unit
    // after the rising edge, and checks are made in that same window.
    task automatic cycle();
        if (bus.mem_start && bus.mem_ready) begin
            pend_valid = 1'b1;
            pend_addr  = bus.mem_addr;
        end
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        bus.mem_data_valid = 1'b0;
        if (pend_valid && resp_en) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data       = pend_addr ^ KEY;
            pend_valid         = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_start"}, 32'(bus.mem_start), 32'd0);
        check({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
        check({tag, "_id_valid"},  32'(bus.id_valid),  32'd0);
        check({tag, "_id_reg_pc"}, bus.id_reg_pc,      32'd0);
        check({tag, "_id_inst"},   bus.id_inst,        NOP);
    endtask

    // Leaves the bench in the first cycle after rst_n rises (FSM in IDLE).
    task automatic do_reset();
        rst_n              = 1'b0;
        pend_valid         = 1'b0;
        resp_en            = 1'b1;
        bus.mem_ready      = 1'b1;
        bus.mem_data       = '0;
        bus.mem_data_valid = 1'b0;
        bus.stall_flg      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        check("rst_release_idle", 32'(bus.mem_start), 32'd0);
    endtask

    initial begin
        // ---- streaming fetch, one instruction per two cycles ----
        do_reset();
        cycle();
        for (int k = 0; k < 4; k++) begin
            check("stream_req_start", 32'(bus.mem_start), 32'd1);
            check("stream_req_addr",  bus.mem_addr,       32'(4 * k));
            cycle();
            check("stream_wait_start", 32'(bus.mem_start), 32'd0);
            cycle();
            check("stream_id_valid", 32'(bus.id_valid), 32'd1);
            check("stream_id_pc",    bus.id_reg_pc,     32'(4 * k));
            check("stream_id_inst",  bus.id_inst,       32'(4 * k) ^ KEY);
        end

        // ---- decode stalled: FIFO fills, FSM idles, then drains ----
        do_reset();
        bus.stall_flg = 1'b1;
        req_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.mem_start) req_cnt++;
            cycle();
            if (bus.id_valid) check("stall_head_pc", bus.id_reg_pc, 32'd0);
        end
        check("stall_req_count", 32'(req_cnt),       32'd4);
        check("stall_idle",      32'(bus.mem_start), 32'd0);
        check("stall_id_valid",  32'(bus.id_valid),  32'd1);
        check("stall_head_inst", bus.id_inst,        KEY);
        bus.stall_flg = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            check("drain_id_valid", 32'(bus.id_valid), 32'd1);
            check("drain_id_pc",    bus.id_reg_pc,     32'(4 * i));
            check("drain_id_inst",  bus.id_inst,       32'(4 * i) ^ KEY);
        end

        // ---- redirect while waiting for pc=8 ----
        do_reset();
        repeat (5) cycle();
        check("redir_wait_addr8",  bus.mem_addr,       32'h8);
        check("redir_wait_start",  32'(bus.mem_start), 32'd1);
        resp_en = 1'b0;
        cycle();
        check("redir_in_wait", 32'(bus.mem_start), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        cycle();
        check("redir_discard_valid", 32'(bus.id_valid),  32'd0);
        check("redir_discard_start", 32'(bus.mem_start), 32'd0);
        resp_en = 1'b1;
        cycle();
        check("redir_drop8_valid", 32'(bus.id_valid),  32'd0);
        check("redir_drop8_start", 32'(bus.mem_start), 32'd0);
        cycle();
        check("redir_req_start", 32'(bus.mem_start), 32'd1);
        check("redir_req_addr",  bus.mem_addr,       32'h100);
        check("redir_req_valid", 32'(bus.id_valid),  32'd0);
        cycle();
        check("redir_resp_valid", 32'(bus.id_valid), 32'd0);
        cycle();
        check("redir_id_valid", 32'(bus.id_valid), 32'd1);
        check("redir_id_pc",    bus.id_reg_pc,     32'h100);
        check("redir_id_inst",  bus.id_inst,       32'h100 ^ KEY);
        check("redir_next_addr", bus.mem_addr,     32'h104);

        // ---- redirect in the same cycle as a response ----
        cycle();
        check("redir2_wait_start", 32'(bus.mem_start), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        cycle();
        check("redir2_req_start", 32'(bus.mem_start), 32'd1);
        check("redir2_req_addr",  bus.mem_addr,       32'h200);
        check("redir2_no_stale",  32'(bus.id_valid),  32'd0);
        cycle();
        check("redir2_no_stale_wait", 32'(bus.id_valid), 32'd0);
        cycle();
        check("redir2_id_valid", 32'(bus.id_valid), 32'd1);
        check("redir2_id_pc",    bus.id_reg_pc,     32'h200);
        check("redir2_id_inst",  bus.id_inst,       32'h200 ^ KEY);
        check("redir2_next_addr", bus.mem_addr,     32'h204);

        // ---- memory not ready for 5 cycles ----
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("notready_start", 32'(bus.mem_start), 32'd1);
            check("notready_addr",  bus.mem_addr,       32'h204);
        end
        bus.mem_ready = 1'b1;
        cycle();
        cycle();
        check("notready_id_pc",     bus.id_reg_pc, 32'h204);
        check("notready_next_addr", bus.mem_addr,  32'h208);

        // ---- asynchronous reset in WAIT with two entries queued ----
        do_reset();
        bus.stall_flg = 1'b1;
        repeat (5) cycle();
        check("arst_pre_valid", 32'(bus.id_valid), 32'd1);
        check("arst_pre_pc",    bus.id_reg_pc,     32'd0);
        check("arst_pre_addr",  bus.mem_addr,      32'h8);
        resp_en = 1'b0;
        cycle();
        check("arst_in_wait", 32'(bus.mem_start), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        #1;
        rst_n              = 1'b1;
        bus.stall_flg      = 1'b0;
        pend_valid         = 1'b0;
        resp_en            = 1'b1;
        bus.mem_data_valid = 1'b1;
        bus.mem_data       = 32'hDEAD_BEEF;
        cycle();
        bus.mem_data_valid = 1'b1;
        bus.mem_data       = 32'hDEAD_BEEF;
        check("arst_restart_start", 32'(bus.mem_start), 32'd1);
        check("arst_restart_addr",  bus.mem_addr,       32'd0);
        check("arst_late_ignored",  32'(bus.id_valid),  32'd0);
        cycle();
        check("arst_wait_valid", 32'(bus.id_valid), 32'd0);
        cycle();
        check("arst_id_valid", 32'(bus.id_valid), 32'd1);
        check("arst_id_pc",    bus.id_reg_pc,     32'd0);
        check("arst_id_inst",  bus.id_inst,       KEY);
        check("arst_next_addr", bus.mem_addr,     32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Parametrised instruction fetch unit for the pipelined core, replacing the fixed single-entry fetch stage. It drives the instruction-memory request/response handshake and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It presents the FIFO head to the decode stage, honours decode back-pressure through `stall_flg`, and flushes on a branch/jump redirect from execute, discarding any in-flight response.

## Interface
- XLEN, 32, PC/address width
- ILEN, 32, instruction width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- NOP_INST, 32'h00000013, value on `id_inst` when FIFO empty

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_start  out  1  instruction request valid
- mem_ready  in  1  memory accepts request this cycle
- mem_addr  out  XLEN  request address
- mem_data  in  ILEN  returned instruction
- mem_data_valid  in  1  `mem_data` valid this cycle
- stall_flg  in  1  decode holds; head not consumed
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new fetch PC
- id_valid  out  1  FIFO non-empty
- id_reg_pc  out  XLEN  PC of head entry (0 when empty)
- id_inst  out  ILEN  head instruction (NOP_INST when empty)

## Operation
- Registers: `fetch_pc`, `req_pc` (PC of outstanding request), FIFO storage {pc, inst} × DEPTH, `rd_ptr`/`wr_ptr` (log2 DEPTH bits, wrap naturally), `count` ($clog2(DEPTH+1) bits), FSM.
- At most one outstanding request.
- The FIFO slot for a request is reserved at issue: issue is allowed only when `count + outstanding < DEPTH`, so a push never hits a full FIFO.
- FSM states:
  - IDLE: `mem_start`=0. Go to REQ when space is available.
  - REQ: `mem_start`=1, `mem_addr`=`fetch_pc`. On `mem_ready`: `req_pc`←`fetch_pc`, `fetch_pc`←`fetch_pc`+4 (mod 2^XLEN), go to WAIT. Otherwise hold; `mem_addr` stays stable.
  - WAIT: on `mem_data_valid`, push {`req_pc`, `mem_data`}, then go to REQ if space remains after the push/pop, else IDLE.
  - DISCARD: wait for `mem_data_valid`, drop the data, then go to REQ.
- Pop when `id_valid` && !`stall_flg`.
- Simultaneous push and pop: `count` unchanged, both pointers advance.
- Redirect (highest priority, overrides stall, push and pop):
  - Clear FIFO (`count`=0, `rd_ptr`=`wr_ptr`=0).
  - `fetch_pc`←`redirect_pc`.
  - Next state:
    - WAIT without `mem_data_valid` this cycle → DISCARD.
    - REQ with `mem_ready` this cycle → DISCARD.
    - DISCARD with no response yet → stays DISCARD.
    - All other cases → REQ. A response arriving in the redirect cycle is dropped.
  - `mem_addr` may change while `mem_start`=1 only in the cycle after a redirect from un-accepted REQ.
- `mem_data_valid` outside WAIT/DISCARD is ignored.
- `mem_data_valid` and `mem_ready` are never acted on in the same state; a response in WAIT does not issue a new request that cycle.

## Timing
- Reset values: FSM=IDLE, `mem_start`=0, `mem_addr`=RESET_PC, `fetch_pc`=RESET_PC, `id_valid`=0, `id_reg_pc`=0, `id_inst`=NOP_INST, `count`=0.
- First cycle after `rst_n` rises: IDLE. Next cycle: REQ with `mem_addr`=RESET_PC.
- `rst_n` low mid-operation: immediate asynchronous clear. A stale response after reset is ignored, since the FSM is not in WAIT.
- Latency: response in cycle T → `id_valid`/`id_inst` visible in T+1 (no bypass).
- Best-case throughput: one instruction per 2 cycles (REQ accepted, response next cycle).
- Redirect in cycle T: `id_valid`=0 in T+1. The first request to `redirect_pc` is in T+1 (REQ), or after the discarded response.
- `mem_start`, `mem_addr`, `id_*` are registered or decoded from registers only; no combinational path from memory inputs.

## Test plan
- Reset release, memory ready=1, responds next cycle with `inst = addr ^ 32'hA5A5_0000`:
  - `mem_addr` sequence 0,4,8,…
  - decode sees (0, 0xA5A50000), (4, 0xA5A50004), … in order, one per 2 cycles.
- `stall_flg`=1 held, DEPTH=4:
  - exactly 4 requests issue, then the FSM idles with `mem_start`=0.
  - the head stays pc=0 throughout.
  - releasing the stall drains 4 entries in 4 cycles.
- Redirect to 0x100 while in WAIT with pc=8 outstanding:
  - the response for 8 is discarded.
  - the next request is 0x100.
  - `id_valid`=0 until the 0x100 instruction arrives.
- Redirect in the same cycle as `mem_data_valid`:
  - the data is dropped.
  - the next request is issued the following cycle at `redirect_pc`.
  - no stale entry is ever visible.
- `mem_ready` held 0 for 5 cycles:
  - `mem_start`=1 and `mem_addr` are stable throughout.
  - `fetch_pc` does not advance.
- Assert `rst_n` low while in WAIT with 2 entries queued:
  - outputs go to reset values immediately.
  - a late `mem_data_valid` is ignored.
  - fetch restarts at RESET_PC.
